// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and types for the FIFO controller and its pointer sub-module.
package fifo_ctrl_pkg;

  localparam int FIFO_WIDTH     = 8;
  localparam int FIFO_DEPTH     = 16;
  localparam int FIFO_ADDR_W    = 4;
  localparam int FIFO_AF_MARGIN = 2;
  localparam int FIFO_AE_LEVEL  = 2;

  typedef logic [FIFO_ADDR_W:0] ptr_t;

endpackage

// File: rtl/fifo_ctrl_ptr.sv
// Wrap-bit FIFO pointer: ADDR_W address bits plus one lap bit, counting modulo 2*DEPTH.
module fifo_ptr
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [ADDR_W:0]   ptr,
  output logic [ADDR_W:0]   ptr_nxt
);

  localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W+1)'(2*DEPTH-1);

  logic [ADDR_W:0] ptr_r;

  // Next pointer value, also used by the parent to precompute registered flags.
  always_comb begin
    ptr_nxt = ptr_r;
    if (inc) begin
      if (ptr_r == PTR_LAST) begin
        ptr_nxt = PTR_ZERO;
      end else begin
        ptr_nxt = ptr_r + PTR_ONE;
      end
    end else begin
      ptr_nxt = ptr_r;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= PTR_ZERO;
    end else begin
      ptr_r <= ptr_nxt;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller driving a registered-output dual-port RAM.
// Optional almost_full/almost_empty outputs under macro FIFO_ALMOST_FLAGS_EN.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  parameter int AF_LEVEL = DEPTH - FIFO_AF_MARGIN,
  parameter int AE_LEVEL = FIFO_AE_LEVEL
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_data_in,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  logic [ADDR_W:0] wr_ptr_s, wr_ptr_nxt_s, rd_ptr_s, rd_ptr_nxt_s;
  logic [ADDR_W:0] count_nxt_s, count_r;
  logic            push_ok_s, pop_ok_s, empty_nxt_s, full_nxt_s;
  logic            empty_r, full_r, rd_valid_r, overflow_r, underflow_r;

  fifo_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wr_ptr (
    .clk(clk), .rst(rst), .inc(push_ok_s), .ptr(wr_ptr_s), .ptr_nxt(wr_ptr_nxt_s)
  );

  fifo_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_ptr (
    .clk(clk), .rst(rst), .inc(pop_ok_s), .ptr(rd_ptr_s), .ptr_nxt(rd_ptr_nxt_s)
  );

  // Request acceptance and next-cycle flags derived from the advanced pointers.
  always_comb begin
    push_ok_s   = wr_en & ~full_r;
    pop_ok_s    = rd_en & ~empty_r;
    count_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    full_nxt_s  = (wr_ptr_nxt_s[ADDR_W-1:0] == rd_ptr_nxt_s[ADDR_W-1:0]) &&
                  (wr_ptr_nxt_s[ADDR_W] != rd_ptr_nxt_s[ADDR_W]);
  end

  // Occupancy, flags, read-valid pipeline and sticky errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r     <= {(ADDR_W+1){1'b0}};
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      rd_valid_r  <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      empty_r     <= empty_nxt_s;
      full_r      <= full_nxt_s;
      rd_valid_r  <= pop_ok_s;
      overflow_r  <= overflow_r | (wr_en & full_r);
      underflow_r <= underflow_r | (rd_en & empty_r);
    end
  end

  // The RAM strobes are combinational so the access lands on the same edge the pointers move.
  assign mem_write   = push_ok_s;
  assign mem_wr_addr = wr_ptr_s[ADDR_W-1:0];
  assign mem_data_in = wr_data;
  assign mem_read    = pop_ok_s;
  assign mem_rd_addr = rd_ptr_s[ADDR_W-1:0];
  assign rd_valid    = rd_valid_r;
  assign full        = full_r;
  assign empty       = empty_r;
  assign count       = count_r;
  assign overflow    = overflow_r;
  assign underflow   = underflow_r;

`ifdef FIFO_ALMOST_FLAGS_EN
  logic almost_full_r, almost_empty_r;

  // Threshold flags, registered from the next-cycle occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
    end else begin
      almost_full_r  <= (count_nxt_s >= (ADDR_W+1)'(AF_LEVEL));
      almost_empty_r <= (count_nxt_s <= (ADDR_W+1)'(AE_LEVEL));
    end
  end

  assign almost_full  = almost_full_r;
  assign almost_empty = almost_empty_r;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard testbench for fifo_ctrl with a behavioural registered-output RAM.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  localparam int W = 8;
  localparam int D = 16;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] wr_data = 8'h00;
  logic         mem_write, mem_read, rd_valid, full, empty, overflow, underflow;
  logic [A-1:0] mem_wr_addr, mem_rd_addr;
  logic [W-1:0] mem_data_in;
  logic [A:0]   count;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic         almost_full, almost_empty;
`endif

  always #5 clk = ~clk;

  fifo_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .mem_write(mem_write), .mem_wr_addr(mem_wr_addr), .mem_data_in(mem_data_in),
    .mem_read(mem_read), .mem_rd_addr(mem_rd_addr), .rd_valid(rd_valid),
    .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
`ifdef FIFO_ALMOST_FLAGS_EN
    , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  logic [W-1:0] ram [0:D-1];
  logic [W-1:0] ram_dout;

  always @(posedge clk) begin
    if (mem_write) ram[mem_wr_addr] <= mem_data_in;
    if (mem_read)  ram_dout <= ram[mem_rd_addr];
  end

  logic [W-1:0] m_q[$];
  logic [W-1:0] exp_q[$];
  ptr_t         m_wp, m_rp;
  logic         m_over, m_under, m_valid;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_wp = 5'd0;
    m_rp = 5'd0;
    m_over = 1'b0;
    m_under = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic check_state();
    logic [W-1:0] e;
    check("count", 32'(count), 32'(m_q.size()));
    check("empty", 32'(empty), 32'(m_q.size() == 0));
    check("full", 32'(full), 32'(m_q.size() == D));
    check("overflow", 32'(overflow), 32'(m_over));
    check("underflow", 32'(underflow), 32'(m_under));
    check("rd_valid", 32'(rd_valid), 32'(m_valid));
`ifdef FIFO_ALMOST_FLAGS_EN
    check("almost_full", 32'(almost_full), 32'(m_q.size() >= D - 2));
    check("almost_empty", 32'(almost_empty), 32'(m_q.size() <= 2));
`endif
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underrun", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("rd_data", 32'(ram_dout), 32'(e));
      end
    end
  endtask

  // Called just after a rising edge; drives one cycle of requests.
  task automatic step(input logic we, input logic [W-1:0] wd, input logic re);
    int   sz;
    logic push_ok, pop_ok;
    wr_en = we;
    wr_data = wd;
    rd_en = re;
    #1;
    sz = m_q.size();
    push_ok = we && (sz < D);
    pop_ok  = re && (sz > 0);
    check("mem_write", 32'(mem_write), 32'(push_ok));
    check("mem_read", 32'(mem_read), 32'(pop_ok));
    check("mem_wr_addr", 32'(mem_wr_addr), 32'(m_wp[A-1:0]));
    check("mem_rd_addr", 32'(mem_rd_addr), 32'(m_rp[A-1:0]));
    if (push_ok) check("mem_data_in", 32'(mem_data_in), 32'(wd));
    if (we && sz == D) m_over = 1'b1;
    if (re && sz == 0) m_under = 1'b1;
    if (pop_ok) begin
      exp_q.push_back(m_q.pop_front());
      m_rp = m_rp + 5'd1;
    end
    if (push_ok) begin
      m_q.push_back(wd);
      m_wp = m_wp + 5'd1;
    end
    m_valid = pop_ok;
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state();
    check("rst_mem_write", 32'(mem_write), 32'(0));
    check("rst_mem_read", 32'(mem_read), 32'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill with 0x11..0x20, then a rejected push, then drain in order.
    for (int i = 0; i < D; i++) step(1'b1, 8'(8'h11 + i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < D; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);

    // Steady push+pop at occupancy 5 wraps both addresses.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Full with both requests, then empty with both requests.
    for (int i = 0; i < D - 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    step(1'b1, 8'h55, 1'b1);
    for (int i = 0; i < D - 1; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h66, 1'b1);

    // Pop the last word, then reset while rd_valid is high.
    step(1'b0, 8'h00, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rd_valid", 32'(rd_valid), 32'(0));
    check("async_count", 32'(count), 32'(0));
    check("async_empty", 32'(empty), 32'(1));
    check("async_full", 32'(full), 32'(0));
    check("async_overflow", 32'(overflow), 32'(0));
    check("async_underflow", 32'(underflow), 32'(0));
    model_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the 16x8 dual-port RAM and drives its write/read strobes and addresses.
- Turns producer push and consumer pop requests into RAM accesses.
- Maintains the pointers, occupancy, full/empty flags and error flags.
- Tells the consumer when the RAM's registered read data is valid.

Parameters:
- WIDTH, 8, data word width; must match the RAM WIDTH.
- DEPTH, 16, number of entries; power of two; must match the RAM DEPTH.
- ADDR_W, 4, address width; must equal log2(DEPTH).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  producer push request.
- wr_data  in  WIDTH  push data.
- rd_en  in  1  consumer pop request.
- mem_write  out  1  RAM write strobe.
- mem_wr_addr  out  ADDR_W  RAM write address.
- mem_data_in  out  WIDTH  RAM write data.
- mem_read  out  1  RAM read strobe.
- mem_rd_addr  out  ADDR_W  RAM read address.
- rd_valid  out  1  RAM data_out holds the popped word this cycle.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (rst low, asynchronous):
  - wr_ptr, rd_ptr and count cleared to 0.
  - empty is 1; full, rd_valid, overflow and underflow are 0.
  - RAM contents are irrelevant after reset.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits; the MSB is a wrap bit.
  - Each pointer increments modulo 2*DEPTH.
  - mem_wr_addr is wr_ptr[ADDR_W-1:0]; mem_rd_addr is rd_ptr[ADDR_W-1:0].
- Flags:
  - empty when wr_ptr equals rd_ptr.
  - full when the low bits are equal and the MSBs differ.
  - Both flags are registered and consistent with count every cycle.
- Accepting requests:
  - push_ok = wr_en & ~full.
  - pop_ok = rd_en & ~empty.
- Combinational RAM drive in the same cycle:
  - mem_write = push_ok; mem_data_in = wr_data.
  - mem_read = pop_ok.
  - Both pointers advance on the following edge.
- Read latency:
  - The RAM registers data_out, so rd_valid is pop_ok delayed by one cycle.
  - rd_valid is high for exactly one cycle per accepted pop.
- Occupancy, next cycle:
  - push only: count+1.
  - pop only: count-1.
  - both or neither: unchanged.
- Simultaneous events:
  - Full with both requests: only the pop is accepted; overflow is set; count becomes DEPTH-1.
  - Empty with both requests: only the push is accepted; underflow is set; there is no bypass path.
  - Otherwise both are accepted.
- Sticky errors:
  - overflow is set on wr_en & full; underflow is set on rd_en & empty.
  - Cleared only by reset.
- Address wrap: after entry DEPTH-1 the address returns to 0 with the wrap bit toggled; there is no bubble.
- Reset mid-operation:
  - Any pending rd_valid is dropped immediately.
  - Words in flight are discarded.

Optional Feature:
- Macro FIFO_ALMOST_FLAGS_EN.
- When defined:
  - Adds parameters AF_LEVEL (default DEPTH-2) and AE_LEVEL (default 2).
  - Adds registered outputs almost_full (count >= AF_LEVEL) and almost_empty (count <= AE_LEVEL).
  - Reset values: almost_full 0, almost_empty 1.
- When undefined: neither the ports nor the logic exist, and the remaining behaviour is identical.

Decomposition:
- Shared package holds:
  - Default WIDTH, DEPTH and ADDR_W constants.
  - A pointer typedef of ADDR_W+1 bits.
  - The default almost-full and almost-empty levels.
- One natural sub-module, fifo_ptr:
  - Wrap-bit pointer with an increment enable and an async active-low reset.
  - Instantiated twice, once for the write side and once for the read side.
- A top-level wrapper pairs fifo_ctrl with the dual-port RAM; the wrapper is outside this block.

Test Plan:
- Reset then idle: rst low for 2 cycles then high -> empty=1, full=0, count=0, all strobes 0.
- Push 0x11..0x1F and 0x20 (16 words): mem_wr_addr steps 0..15 -> full=1, count=16. Pop 16 words -> rd_valid one cycle after each pop; RAM data_out reads 0x11..0x20 in order; empty=1 at the end.
- Full, then wr_en=1 with wr_data=0xAA -> mem_write=0, overflow=1, count stays 16; the pop that follows returns 0x11.
- Empty, then rd_en=1 -> mem_read=0, underflow=1, rd_valid stays 0.
- With count=5:
  - Push and pop together for 20 cycles -> count stays 5 and both addresses wrap 15->0.
  - Full with both requests -> count becomes 15.
  - Empty with both requests -> count becomes 1.
- Assert rst during a pop cycle -> rd_valid=0 immediately; count=0 and empty=1 asynchronously.
